// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and halt sequencing
// for the PC, IF/ID and ID/EX registers, plus saturating performance counters.
module hazard_ctrl #(
  parameter int unsigned LU_CYCLES = 1,
  parameter int unsigned HALT_CODE = 10,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_uses_rs,
  input  logic             i_id_uses_rt,
  input  logic [4:0]       i_ex_wreg,
  input  logic             i_ex_ld,
  input  logic             i_ex_regwrite,
  input  logic             i_ex_taken,
  input  logic             i_ex_syscall,
  input  logic [31:0]      i_ex_v0,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_idex_en,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic [CNT_W-1:0] o_cycle_cnt
);

  typedef enum logic [1:0] {StRun, StLuStall, StHalt} state_e;

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [3:0]       LuStart = 4'(LU_CYCLES - 1);

  state_e           r_state, w_state_nxt;
  logic [3:0]       r_lu_left, w_lu_left_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_cycle_cnt;
  logic             w_lu_hit, w_halt_hit;
  logic             w_stall_inc, w_flush_inc, w_cycle_inc;

  assign w_lu_hit = i_ex_ld & i_ex_regwrite & (i_ex_wreg != 5'd0) &
                    ((i_id_uses_rs & (i_id_rs == i_ex_wreg)) |
                     (i_id_uses_rt & (i_id_rt == i_ex_wreg)));
  assign w_halt_hit = i_ex_syscall & (i_ex_v0 == 32'(HALT_CODE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StRun;
      r_lu_left <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_lu_left <= w_lu_left_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lu_left_nxt = r_lu_left;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    w_cycle_inc   = (r_state != StHalt);
    case (r_state)
      StRun: begin
        if (w_halt_hit) begin
          w_state_nxt = StHalt;
        end else if (i_ex_taken) begin
          w_flush_inc = 1'b1;
        end else if (w_lu_hit) begin
          w_stall_inc = 1'b1;
          if (LU_CYCLES > 1) begin
            w_state_nxt   = StLuStall;
            w_lu_left_nxt = LuStart;
          end
        end
      end
      StLuStall: begin
        // EX holds a bubble here, so taken/halt inputs are meaningless and ignored
        w_stall_inc   = 1'b1;
        w_lu_left_nxt = r_lu_left - 4'd1;
        if (r_lu_left == 4'd1) w_state_nxt = StRun;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_pc_en      = 1'b0;
    o_ifid_en    = 1'b0;
    o_idex_en    = 1'b0;
    o_ifid_flush = 1'b0;
    o_idex_flush = 1'b0;
    o_halted     = 1'b0;
    case (r_state)
      StRun: begin
        if (w_halt_hit || (!i_ex_taken && w_lu_hit)) begin
          o_idex_en    = 1'b1;
          o_idex_flush = 1'b1;
        end else begin
          o_pc_en      = 1'b1;
          o_ifid_en    = 1'b1;
          o_idex_en    = 1'b1;
          o_ifid_flush = i_ex_taken;
          o_idex_flush = i_ex_taken;
        end
      end
      StLuStall: begin
        o_idex_en    = 1'b1;
        o_idex_flush = 1'b1;
      end
      StHalt:  o_halted = 1'b1;
      default: ;
    endcase
    // Reset forces every pipeline register to hold while it is asserted
    if (!rst_n) begin
      o_pc_en      = 1'b0;
      o_ifid_en    = 1'b0;
      o_idex_en    = 1'b0;
      o_ifid_flush = 1'b0;
      o_idex_flush = 1'b0;
      o_halted     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_cycle_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CntOne;
      if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CntOne;
      if (w_cycle_inc && (r_cycle_cnt != '1)) r_cycle_cnt <= r_cycle_cnt + CntOne;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
  assign o_cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a default instance (LU_CYCLES=1, CNT_W=32) and a
// slow-memory narrow-counter instance (LU_CYCLES=3, CNT_W=4) share one stimulus bus.
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        urs;
    logic        urt;
    logic [4:0]  wreg;
    logic        ld;
    logic        rw;
    logic        taken;
    logic        sys;
    logic [31:0] v0;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs, id_rt, ex_wreg;
  logic id_uses_rs, id_uses_rt, ex_ld, ex_regwrite, ex_taken, ex_syscall;
  logic [31:0] ex_v0;

  logic a_pc, a_ifid, a_idex, a_iff, a_idf, a_h;
  logic [31:0] a_st, a_fl, a_cy;
  logic b_pc, b_ifid, b_idex, b_iff, b_idf, b_h;
  logic [3:0] b_st, b_fl, b_cy;

  int checks = 0;
  int failures = 0;
  logic [101:0] exp_q[$];

  always #5 clk = ~clk;

  hazard_ctrl u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rs(id_uses_rs), .i_id_uses_rt(id_uses_rt),
    .i_ex_wreg(ex_wreg), .i_ex_ld(ex_ld), .i_ex_regwrite(ex_regwrite), .i_ex_taken(ex_taken),
    .i_ex_syscall(ex_syscall), .i_ex_v0(ex_v0),
    .o_pc_en(a_pc), .o_ifid_en(a_ifid), .o_idex_en(a_idex), .o_ifid_flush(a_iff),
    .o_idex_flush(a_idf), .o_halted(a_h),
    .o_stall_cnt(a_st), .o_flush_cnt(a_fl), .o_cycle_cnt(a_cy)
  );

  hazard_ctrl #(.LU_CYCLES(3), .HALT_CODE(10), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rs(id_uses_rs), .i_id_uses_rt(id_uses_rt),
    .i_ex_wreg(ex_wreg), .i_ex_ld(ex_ld), .i_ex_regwrite(ex_regwrite), .i_ex_taken(ex_taken),
    .i_ex_syscall(ex_syscall), .i_ex_v0(ex_v0),
    .o_pc_en(b_pc), .o_ifid_en(b_ifid), .o_idex_en(b_idex), .o_ifid_flush(b_iff),
    .o_idex_flush(b_idf), .o_halted(b_h),
    .o_stall_cnt(b_st), .o_flush_cnt(b_fl), .o_cycle_cnt(b_cy)
  );

  function automatic stim_t mk_s(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                                 input logic urt, input logic [4:0] wreg, input logic ld,
                                 input logic rw, input logic taken, input logic sys,
                                 input logic [31:0] v0);
    stim_t s;
    s.rs = rs; s.rt = rt; s.urs = urs; s.urt = urt; s.wreg = wreg;
    s.ld = ld; s.rw = rw; s.taken = taken; s.sys = sys; s.v0 = v0;
    return s;
  endfunction

  function automatic stim_t s_idle();
    return mk_s(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endfunction

  // Load of $t0 in EX, ID reading rs=8
  function automatic stim_t s_lu_rs();
    return mk_s(5'd8, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
  endfunction

  // {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, halted, stall, flush, cycle}
  function automatic logic [101:0] ev(input logic [5:0] o, input int st, input int fl,
                                      input int cy);
    return {o, 32'(st), 32'(fl), 32'(cy)};
  endfunction

  localparam logic [5:0] ORun   = 6'b111000;
  localparam logic [5:0] OStall = 6'b001010;
  localparam logic [5:0] OFlush = 6'b111110;
  localparam logic [5:0] OHalt  = 6'b000001;
  localparam logic [5:0] OOff   = 6'b000000;

  task automatic drive(input stim_t s);
    id_rs = s.rs; id_rt = s.rt; id_uses_rs = s.urs; id_uses_rt = s.urt;
    ex_wreg = s.wreg; ex_ld = s.ld; ex_regwrite = s.rw; ex_taken = s.taken;
    ex_syscall = s.sys; ex_v0 = s.v0;
  endtask

  task automatic sample(input bit sel_b, output logic [101:0] v);
    if (!sel_b) v = {a_pc, a_ifid, a_idex, a_iff, a_idf, a_h, a_st, a_fl, a_cy};
    else v = {b_pc, b_ifid, b_idex, b_iff, b_idf, b_h, 28'd0, b_st, 28'd0, b_fl, 28'd0, b_cy};
  endtask

  task automatic do_reset();
    drive(s_idle());
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [101:0] obs, e;
    rst_n = 1'b0;
    drive(s_lu_rs());
    #2;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(ev(OOff, 0, 0, 0));
      sample(k[0], obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset dut%0d got=%h want=%h", k, obs, e);
      end
    end
    do_reset();
  endtask

  task automatic test_load_use();
    stim_t st[5];
    logic [101:0] ex[5];
    logic [101:0] obs, e;
    do_reset();
    st[0] = s_lu_rs();                                                     ex[0] = ev(OStall, 0, 0, 0);
    st[1] = s_idle();                                                      ex[1] = ev(ORun, 1, 0, 1);
    st[2] = mk_s(5'd3, 5'd8, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 0); ex[2] = ev(OStall, 1, 0, 2);
    st[3] = s_idle();                                                      ex[3] = ev(ORun, 2, 0, 3);
    st[4] = mk_s(5'd8, 5'd8, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 0); ex[4] = ev(ORun, 2, 0, 4);
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      sample(1'b0, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL load_use cyc%0d got=%h want=%h", i, obs, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_taken_lu();
    stim_t st[2];
    logic [101:0] ex[2];
    logic [101:0] obs, e;
    do_reset();
    st[0] = s_lu_rs();
    st[0].taken = 1'b1;  ex[0] = ev(OFlush, 0, 0, 0);
    st[1] = s_idle();    ex[1] = ev(ORun, 0, 1, 1);
    for (int i = 0; i < 2; i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      sample(1'b0, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL taken_lu cyc%0d got=%h want=%h", i, obs, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_zero_reg();
    stim_t st[2];
    logic [101:0] ex[2];
    logic [101:0] obs, e;
    do_reset();
    st[0] = mk_s(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0); ex[0] = ev(ORun, 0, 0, 0);
    st[1] = s_idle();                                                      ex[1] = ev(ORun, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      sample(1'b0, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL zero_reg cyc%0d got=%h want=%h", i, obs, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_halt();
    stim_t st[5];
    logic [101:0] ex[5];
    logic [101:0] obs, e;
    do_reset();
    st[0] = mk_s(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd4);
    ex[0] = ev(ORun, 0, 0, 0);
    st[1] = mk_s(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd10);
    ex[1] = ev(OStall, 0, 0, 1);
    st[2] = s_idle();
    ex[2] = ev(OHalt, 0, 0, 2);
    st[3] = s_lu_rs();
    st[3].taken = 1'b1;
    ex[3] = ev(OHalt, 0, 0, 2);
    st[4] = s_lu_rs();
    ex[4] = ev(OHalt, 0, 0, 2);
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      sample(1'b0, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL halt cyc%0d got=%h want=%h", i, obs, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_lu_multi();
    stim_t st[4];
    logic [101:0] ex[4];
    logic [101:0] obs, e;
    do_reset();
    st[0] = s_lu_rs();  ex[0] = ev(OStall, 0, 0, 0);
    st[1] = s_idle();
    st[1].taken = 1'b1; ex[1] = ev(OStall, 1, 0, 1);
    st[2] = s_idle();   ex[2] = ev(OStall, 2, 0, 2);
    st[3] = s_idle();   ex[3] = ev(ORun, 3, 0, 3);
    for (int i = 0; i < 4; i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      sample(1'b1, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL lu_multi cyc%0d got=%h want=%h", i, obs, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[3];
    logic [101:0] ex[3];
    logic [101:0] obs, e;
    do_reset();
    st[0] = s_lu_rs(); ex[0] = ev(OStall, 0, 0, 0);
    st[1] = s_lu_rs(); ex[1] = ev(OStall, 1, 0, 1);
    st[2] = s_idle();  ex[2] = ev(ORun, 2, 0, 2);
    for (int i = 0; i < 3; i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      sample(1'b0, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL back_to_back cyc%0d got=%h want=%h", i, obs, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_saturate();
    stim_t s;
    logic [101:0] obs, e;
    int sat;
    do_reset();
    // 20 taken branches, then a hazard, one stall cycle, and a reset mid-stall
    for (int i = 0; i < 25; i++) begin
      sat = (i > 15) ? 15 : i;
      if (i < 20) begin
        s = s_idle();
        s.taken = 1'b1;
        exp_q.push_back(ev(OFlush, 0, sat, sat));
      end else if (i == 20) begin
        s = s_lu_rs();
        exp_q.push_back(ev(OStall, 0, 15, 15));
      end else if (i == 21) begin
        s = s_lu_rs();
        exp_q.push_back(ev(OStall, 1, 15, 15));
      end else begin
        s = s_idle();
        exp_q.push_back(ev(ORun, 0, 0, i - 22));
      end
      drive(s);
      @(negedge clk);
      sample(1'b1, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL saturate cyc%0d got=%h want=%h", i, obs, e);
      end
      if (i == 21) begin
        #1 rst_n = 1'b0;
        #1;
        exp_q.push_back(ev(OOff, 0, 0, 0));
        sample(1'b1, obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL reset_mid_stall got=%h want=%h", obs, e);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_taken_lu();
    test_zero_reg();
    test_halt();
    test_lu_multi();
    test_back_to_back();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
